// File: rtl/axi4_burst_master_pkg.sv
// Shared types and response helpers for the AXI4 burst initiator.
// FSM state encoding, AXI response codes and the response-merge function.
package axi4_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        WD,
        WB,
        AR,
        RD,
        DONE
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Response severity follows the encoding, so the worst is the larger code.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_burst_master_if.sv
// Five-channel AXI4 subset between the burst initiator (master) and a memory slave.
interface axi4_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWVALID, input AWREADY,
        output WDATA, WLAST, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARVALID, input ARREADY,
        input  RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWVALID, output AWREADY,
        input  WDATA, WLAST, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARVALID, output ARREADY,
        output RDATA, RRESP, RLAST, RVALID, input RREADY
    );

endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 burst initiator: one command in, one AW/AR plus data
// beats on the bus, one completion report out.
module axi4_burst_master
    import axi4_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,

    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,

    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic                  done_err,

    axi4_burst_master_if.master   axi
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [1:0]            worst_q, worst_d;
    logic                  err_q, err_d;
    logic                  live_q, live_d;

    logic [7:0] cnt_inc;
    logic       cnt_at_len;

    assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign cnt_at_len = (cnt_q == len_q);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            worst_q <= OKAY;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            worst_q <= worst_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        worst_d = worst_q;
        err_d   = err_q;
        // Keeps cmd_ready low during reset and for the first cycle after release.
        live_d  = 1'b1;

        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        rd_data     = '0;
        rd_valid    = 1'b0;
        rd_last     = 1'b0;
        done_valid  = 1'b0;
        done_resp   = OKAY;
        done_err    = 1'b0;

        axi.AWADDR  = addr_q;
        axi.AWLEN   = len_q;
        axi.AWSIZE  = size_q;
        axi.AWVALID = 1'b0;
        axi.WDATA   = '0;
        axi.WLAST   = 1'b0;
        axi.WVALID  = 1'b0;
        axi.BREADY  = 1'b0;
        axi.ARADDR  = addr_q;
        axi.ARLEN   = len_q;
        axi.ARSIZE  = size_q;
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = live_q;
                if (cmd_valid && live_q) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    size_d  = cmd_size;
                    cnt_d   = '0;
                    worst_d = OKAY;
                    err_d   = 1'b0;
                    state_d = cmd_write ? AW : AR;
                end
            end
            AW: begin
                axi.AWVALID = 1'b1;
                if (axi.AWREADY) state_d = WD;
            end
            WD: begin
                axi.WDATA  = wr_data;
                axi.WVALID = wr_valid;
                axi.WLAST  = cnt_at_len;
                wr_ready   = axi.WREADY;
                if (wr_valid && axi.WREADY) begin
                    cnt_d = cnt_inc;
                    if (cnt_at_len) state_d = WB;
                end
            end
            WB: begin
                axi.BREADY = 1'b1;
                if (axi.BVALID) begin
                    worst_d = axi.BRESP;
                    state_d = DONE;
                end
            end
            AR: begin
                axi.ARVALID = 1'b1;
                if (axi.ARREADY) state_d = RD;
            end
            RD: begin
                rd_data    = axi.RDATA;
                rd_valid   = axi.RVALID;
                rd_last    = axi.RLAST;
                axi.RREADY = rd_ready;
                if (axi.RVALID && rd_ready) begin
                    worst_d = resp_worst(worst_q, axi.RRESP);
                    cnt_d   = cnt_inc;
                    // RLAST early/late both flag err; a missing RLAST keeps us reading.
                    if (axi.RLAST) begin
                        if (!cnt_at_len) err_d = 1'b1;
                        state_d = DONE;
                    end else if (cnt_at_len) begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                done_valid = 1'b1;
                done_resp  = worst_q;
                done_err   = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: the bench plays the AXI slave, the write
// source and the read sink; bursts come from a vector table plus reset sequences.
module tb_axi4_burst_master;
    import axi4_master_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready = 1'b0, rd_last;
    logic        done_valid, done_err;
    logic [1:0]  done_resp;

    int n_chk = 0;
    int n_fail = 0;

    axi4_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
        .axi(bus.master)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        int          ax_wait;
        logic        bp;
        int          rd_stall;
        int          rlast_at;
        int          resp_beat;
        logic [1:0]  resp;
        logic [31:0] dbase;
        logic [1:0]  exp_resp;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic outs_nonzero();
        return |{cmd_ready, wr_ready, rd_data, rd_valid, rd_last, done_valid, done_resp, done_err,
                 bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWVALID, bus.WDATA, bus.WLAST, bus.WVALID,
                 bus.BREADY, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARVALID, bus.RREADY};
    endfunction

    task automatic clear_slave();
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;
        bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00; bus.RLAST = 1'b0;
        wr_valid = 1'b0; rd_ready = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, beat, waitc;
        logic hs, ok, tog;
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len; cmd_size = v.size;
        #1 check("cmd_ready", cmd_ready, 1);

        // Address phase: AxVALID must be up the cycle after acceptance and stay stable.
        cyc = 0; hs = 0; ok = 1; waitc = 0;
        while (!hs && waitc < 64) begin
            @(negedge ACLK);
            cmd_valid = 1'b0;
            bus.AWREADY = v.write && (waitc >= v.ax_wait);
            bus.ARREADY = !v.write && (waitc >= v.ax_wait);
            #1; cyc++;
            if (v.write) begin
                ok &= bus.AWVALID && !bus.ARVALID && bus.AWADDR == v.addr && bus.AWLEN == v.len && bus.AWSIZE == v.size;
                hs = bus.AWVALID && bus.AWREADY;
            end else begin
                ok &= bus.ARVALID && !bus.AWVALID && bus.ARADDR == v.addr && bus.ARLEN == v.len && bus.ARSIZE == v.size;
                hs = bus.ARVALID && bus.ARREADY;
            end
            waitc++;
        end
        check("addr_phase", {30'd0, hs, ok}, 32'd3);

        if (v.write) begin
            beat = 0; waitc = 0; tog = 1'b0;
            while (beat <= int'(v.len) && waitc < 256) begin
                @(negedge ACLK);
                bus.AWREADY = 1'b0;
                wr_valid = 1'b1; wr_data = v.dbase + beat;
                bus.WREADY = v.bp ? tog : 1'b1; tog = ~tog;
                #1; cyc++;
                if (waitc == 0) check("awvalid_drop", bus.AWVALID, 0);
                if (wr_ready !== bus.WREADY || bus.WVALID !== 1'b1) check("w_passthru", {wr_ready, bus.WVALID}, {bus.WREADY, 1'b1});
                if (bus.WVALID && bus.WREADY) begin
                    check("wdata", bus.WDATA, v.dbase + beat);
                    check("wlast", bus.WLAST, beat == int'(v.len));
                    beat++;
                end
                waitc++;
            end
            check("w_beats", beat, int'(v.len) + 1);
            hs = 0; waitc = 0;
            while (!hs && waitc < 16) begin
                @(negedge ACLK);
                wr_valid = 1'b0; bus.WREADY = 1'b0;
                bus.BVALID = 1'b1; bus.BRESP = v.resp;
                #1; cyc++;
                hs = bus.BREADY;
                waitc++;
            end
            check("b_handshake", hs, 1);
        end else begin
            beat = 0; waitc = 0; hs = 0;
            while (!hs && waitc < 64) begin
                @(negedge ACLK);
                bus.ARREADY = 1'b0;
                bus.RVALID = 1'b1; bus.RDATA = v.dbase + beat;
                bus.RRESP = (beat == v.resp_beat) ? v.resp : OKAY;
                bus.RLAST = (beat == v.rlast_at);
                rd_ready = (waitc >= v.rd_stall);
                #1; cyc++;
                if (waitc == 0) check("arvalid_drop", bus.ARVALID, 0);
                if (bus.RREADY !== rd_ready) check("rready_passthru", bus.RREADY, rd_ready);
                if (rd_valid && rd_ready) begin
                    check("rd_data", rd_data, v.dbase + beat);
                    check("rd_last", rd_last, beat == v.rlast_at);
                    hs = bus.RLAST;
                    beat++;
                end
                waitc++;
            end
            check("r_beats", beat, v.rlast_at + 1);
        end

        @(negedge ACLK);
        clear_slave();
        #1; cyc++;
        check("done_valid", done_valid, 1);
        check("done_resp", done_resp, v.exp_resp);
        check("done_err", done_err, v.exp_err);
        if (v.exp_cyc != 0) check("burst_cycles", cyc, v.exp_cyc);
        @(negedge ACLK);
        #1 check("done_pulse_then_idle", {done_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        logic seen;
        vecs[0] = '{write:1, addr:16'h0010, len:3, size:2, ax_wait:0, bp:0, rd_stall:0, rlast_at:0, resp_beat:0,
                    resp:OKAY,   dbase:32'hA0, exp_resp:OKAY,   exp_err:0, exp_cyc:7};
        vecs[1] = '{write:0, addr:16'h0020, len:0, size:2, ax_wait:0, bp:0, rd_stall:0, rlast_at:0, resp_beat:0,
                    resp:SLVERR, dbase:32'hC0, exp_resp:SLVERR, exp_err:0, exp_cyc:3};
        vecs[2] = '{write:1, addr:16'h1234, len:2, size:2, ax_wait:5, bp:1, rd_stall:0, rlast_at:0, resp_beat:0,
                    resp:SLVERR, dbase:32'hB0, exp_resp:SLVERR, exp_err:0, exp_cyc:0};
        vecs[3] = '{write:0, addr:16'h0100, len:3, size:2, ax_wait:2, bp:0, rd_stall:3, rlast_at:3, resp_beat:2,
                    resp:EXOKAY, dbase:32'hD0, exp_resp:EXOKAY, exp_err:0, exp_cyc:0};
        vecs[4] = '{write:0, addr:16'h0200, len:3, size:2, ax_wait:0, bp:0, rd_stall:0, rlast_at:1, resp_beat:0,
                    resp:OKAY,   dbase:32'hE0, exp_resp:OKAY,   exp_err:1, exp_cyc:0};
        vecs[5] = '{write:0, addr:16'h0300, len:1, size:1, ax_wait:1, bp:0, rd_stall:0, rlast_at:3, resp_beat:3,
                    resp:DECERR, dbase:32'hF0, exp_resp:DECERR, exp_err:1, exp_cyc:0};
        vecs[6] = '{write:1, addr:16'hFFFC, len:0, size:0, ax_wait:0, bp:0, rd_stall:0, rlast_at:0, resp_beat:0,
                    resp:DECERR, dbase:32'h55, exp_resp:DECERR, exp_err:0, exp_cyc:4};

        clear_slave();
        repeat (3) @(negedge ACLK);
        #1 check("reset_outputs_zero", outs_nonzero(), 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1 check("cmd_ready_at_release", {cmd_ready, outs_nonzero()}, 2'b00);
        @(negedge ACLK);
        #1 check("cmd_ready_after_release", {cmd_ready, bus.AWVALID, bus.ARVALID}, 3'b100);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a write burst, on beat 2 of 4.
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0400; cmd_len = 3; cmd_size = 2;
        @(negedge ACLK);
        cmd_valid = 1'b0; bus.AWREADY = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge ACLK);
            bus.AWREADY = 1'b0; wr_valid = 1'b1; wr_data = 32'h70 + b; bus.WREADY = 1'b1;
        end
        @(negedge ACLK);
        wr_data = 32'h72;
        #1 check("mid_burst_wvalid", bus.WVALID, 1);
        ARESETn = 1'b0;
        #1 check("mid_reset_outputs_zero", outs_nonzero(), 0);
        clear_slave();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge ACLK);
            #1 seen |= done_valid;
        end
        check("no_done_after_reset", seen, 0);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
